// File: rtl/return_address_stack_pkg.sv
// ============================================================================
// Module      : return_address_stack_pkg
// Description : Shared constants and types for the SAP-2 return-address stack.
//               ADDR_WIDTH is the CPU program-counter width; RAS_DEPTH is the
//               default number of stacked return addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package return_address_stack_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int RAS_DEPTH  = 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Decoded {push, pop} request for one clock cycle.
  typedef enum logic [1:0] {
    RAS_IDLE = 2'b00,
    RAS_POP  = 2'b01,
    RAS_PUSH = 2'b10,
    RAS_SWAP = 2'b11
  } ras_op_e;

endpackage

`default_nettype wire

// File: rtl/return_address_stack_if.sv
// ============================================================================
// Module      : return_address_stack_if
// Description : Control-unit <-> return-address-stack signal bundle.
//   master (control unit) drives : push, pop, push_addr, clear_err
//   slave  (stack)        drives : ret_addr, ret_valid, top_addr, level,
//                                  empty, full, overflow, underflow
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface return_address_stack_if
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH
) ();

  logic                         push;
  logic                         pop;
  addr_t                        push_addr;
  logic                         clear_err;
  addr_t                        ret_addr;
  logic                         ret_valid;
  addr_t                        top_addr;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         empty;
  logic                         full;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output push, pop, push_addr, clear_err,
    input  ret_addr, ret_valid, top_addr, level, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr, clear_err,
    output ret_addr, ret_valid, top_addr, level, empty, full, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/return_address_stack.sv
// ============================================================================
// Module      : return_address_stack
// Description : Hardware return-address stack for the CALL/RET path.
//               CALL pushes the next-instruction address; RET pops it and the
//               address appears one cycle later on ret_addr with a one-cycle
//               ret_valid pulse, ready for the PC parallel load.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low
//               bus   - return_address_stack_if.slave (push/pop/push_addr/
//                       clear_err in; ret_addr/ret_valid/top_addr/level/
//                       empty/full/overflow/underflow out)
// Parameters  : DEPTH - number of entries, must be >= 2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH
) (
  input  wire logic               clk,
  input  wire logic               reset,
  return_address_stack_if.slave   bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // Storage is intentionally left out of reset; only sp defines validity.
  addr_t           mem_q [DEPTH];
  logic [LW-1:0]   sp_q, sp_d;
  addr_t           ret_addr_q, ret_addr_d;
  logic            ret_valid_q, ret_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  ras_op_e         w_op;
  logic            w_empty, w_full;
  logic [IW-1:0]   w_top_idx, w_sp_idx, w_wr_idx;
  logic            w_wr_en;
  logic            w_ovf_set, w_udf_set;

  assign w_op      = ras_op_e'({bus.push, bus.pop});
  assign w_empty   = (sp_q == '0);
  assign w_full    = (sp_q == LW'(DEPTH));
  // Both indices wrap harmlessly in the states where they are unused
  // (top when empty, sp when full).
  assign w_top_idx = IW'(sp_q - 1'b1);
  assign w_sp_idx  = IW'(sp_q);

  always_comb begin
    sp_d        = sp_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_sp_idx;
    w_ovf_set   = 1'b0;
    w_udf_set   = 1'b0;

    case (w_op)
      RAS_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_wr_en = 1'b1;
          sp_d    = sp_q + 1'b1;
        end
      end
      RAS_POP: begin
        if (w_empty) begin
          w_udf_set = 1'b1;
        end else begin
          ret_addr_d  = mem_q[w_top_idx];
          ret_valid_d = 1'b1;
          sp_d        = sp_q - 1'b1;
        end
      end
      RAS_SWAP: begin
        if (w_empty) begin
          // The pop faults but the push still lands in slot 0.
          w_udf_set = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_idx  = '0;
          sp_d      = LW'(1);
        end else begin
          // Replace the top entry in place; works even when full.
          ret_addr_d  = mem_q[w_top_idx];
          ret_valid_d = 1'b1;
          w_wr_en     = 1'b1;
          w_wr_idx    = w_top_idx;
        end
      end
      default: ;
    endcase

    // A new error in the same cycle as clear_err takes priority.
    overflow_d  = (overflow_q  & ~bus.clear_err) | w_ovf_set;
    underflow_d = (underflow_q & ~bus.clear_err) | w_udf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q        <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_idx] <= bus.push_addr;
    end
  end

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.top_addr  = w_empty ? '0 : mem_q[w_top_idx];
  assign bus.level     = sp_q;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_return_address_stack.sv
// ============================================================================
// Module      : tb_return_address_stack
// Description : Self-checking bench for return_address_stack: directed vector
//               table, overflow/underflow/reset corner sequences, randomized
//               traffic against a queue-based reference, and a CALL/RET loop
//               with a modelled program counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_return_address_stack;
  import return_address_stack_pkg::*;

  localparam int DEPTH = RAS_DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  return_address_stack_if #(.DEPTH(DEPTH)) bus ();

  return_address_stack #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue whose back is the top of stack.
  addr_t stk[$];
  addr_t m_ra;
  logic  m_rv, m_ovf, m_udf;

  typedef struct {
    logic  push, pop, clr;
    addr_t addr;
    int    lvl;
    addr_t top;
    logic  rv;
    addr_t ra;
    logic  ovf, udf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ra  = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic c, input addr_t a);
    logic new_ovf;
    logic new_udf;
    new_ovf = 1'b0;
    new_udf = 1'b0;
    m_rv    = 1'b0;
    if (q) begin
      if (stk.size() == 0) begin
        new_udf = 1'b1;
        if (p) stk.push_back(a);
      end else begin
        m_ra = stk.pop_back();
        m_rv = 1'b1;
        if (p) stk.push_back(a);
      end
    end else if (p) begin
      if (stk.size() == DEPTH) new_ovf = 1'b1;
      else                     stk.push_back(a);
    end
    m_ovf = new_ovf | (m_ovf & ~c);
    m_udf = new_udf | (m_udf & ~c);
  endtask

  // Apply one cycle of inputs, advance the model, then sample 1 time unit later.
  task automatic drive(input logic p, input logic q, input logic c, input addr_t a);
    bus.push      = p;
    bus.pop       = q;
    bus.clear_err = c;
    bus.push_addr = a;
    @(posedge clk);
    model_step(p, q, c, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    addr_t exp_top;
    exp_top = (stk.size() == 0) ? addr_t'(0) : stk[stk.size()-1];
    check({tag, ".level"},     32'(bus.level), 32'(stk.size()));
    check({tag, ".top"},       32'(bus.top_addr), 32'(exp_top));
    check({tag, ".empty"},     32'(bus.empty), 32'(stk.size() == 0));
    check({tag, ".full"},      32'(bus.full), 32'(stk.size() == DEPTH));
    check({tag, ".ret_addr"},  32'(bus.ret_addr), 32'(m_ra));
    check({tag, ".ret_valid"}, 32'(bus.ret_valid), 32'(m_rv));
    check({tag, ".overflow"},  32'(bus.overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".level"},     32'(bus.level), 0);
    check({tag, ".empty"},     32'(bus.empty), 1);
    check({tag, ".full"},      32'(bus.full), 0);
    check({tag, ".top"},       32'(bus.top_addr), 0);
    check({tag, ".ret_addr"},  32'(bus.ret_addr), 0);
    check({tag, ".ret_valid"}, 32'(bus.ret_valid), 0);
    check({tag, ".overflow"},  32'(bus.overflow), 0);
    check({tag, ".underflow"}, 32'(bus.underflow), 0);
  endtask

  function automatic vec_t mk(input logic p, input logic q, input logic c, input addr_t a,
                              input int lvl, input addr_t top, input logic rv,
                              input addr_t ra, input logic ovf, input logic udf);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.addr = a;
    v.lvl = lvl; v.top = top; v.rv = rv; v.ra = ra; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    vec_t  tbl[14];
    addr_t pc;
    logic  ld, call, ret;
    addr_t la;
    int    loads;

    //             push pop clr addr      lvl top      rv ra       ovf udf
    tbl[0]  = mk(1, 0, 0, 16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 0, 0, 16'h0034, 2, 16'h0034, 0, 16'h0000, 0, 0);
    tbl[2]  = mk(1, 0, 0, 16'h0056, 3, 16'h0056, 0, 16'h0000, 0, 0);
    tbl[3]  = mk(0, 1, 0, 16'h0000, 2, 16'h0034, 1, 16'h0056, 0, 0);
    tbl[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h0012, 1, 16'h0034, 0, 0);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 0, 0);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 0);
    tbl[7]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 1);
    tbl[8]  = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 0);
    tbl[9]  = mk(0, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 1);
    tbl[10] = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 0);
    tbl[11] = mk(1, 0, 0, 16'h0010, 1, 16'h0010, 0, 16'h0012, 0, 0);
    tbl[12] = mk(1, 0, 0, 16'h0020, 2, 16'h0020, 0, 16'h0012, 0, 0);
    tbl[13] = mk(1, 1, 0, 16'h0099, 2, 16'h0099, 1, 16'h0020, 0, 0);

    // ---------------- reset ----------------
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.clear_err = 1'b0;
    bus.push_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].addr);
      check($sformatf("row%0d.level", i),     32'(bus.level), 32'(tbl[i].lvl));
      check($sformatf("row%0d.top", i),       32'(bus.top_addr), 32'(tbl[i].top));
      check($sformatf("row%0d.empty", i),     32'(bus.empty), 32'(tbl[i].lvl == 0));
      check($sformatf("row%0d.full", i),      32'(bus.full), 32'(tbl[i].lvl == DEPTH));
      check($sformatf("row%0d.ret_valid", i), 32'(bus.ret_valid), 32'(tbl[i].rv));
      check($sformatf("row%0d.ret_addr", i),  32'(bus.ret_addr), 32'(tbl[i].ra));
      check($sformatf("row%0d.overflow", i),  32'(bus.overflow), 32'(tbl[i].ovf));
      check($sformatf("row%0d.underflow", i), 32'(bus.underflow), 32'(tbl[i].udf));
    end

    // ---------------- fill, overflow, swap-at-full ----------------
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    check("drain.empty", 32'(bus.empty), 1);
    for (int i = 1; i <= DEPTH; i++) drive(1, 0, 0, addr_t'(i));
    check("fill.full", 32'(bus.full), 1);
    check("fill.level", 32'(bus.level), 32'(DEPTH));
    check("fill.overflow", 32'(bus.overflow), 0);
    drive(1, 0, 0, 16'h00FF);
    check("ovf.full", 32'(bus.full), 1);
    check("ovf.overflow", 32'(bus.overflow), 1);
    check("ovf.top", 32'(bus.top_addr), 32'h08);
    check("ovf.level", 32'(bus.level), 32'(DEPTH));
    drive(1, 1, 0, 16'h00AA);
    check("fullswap.ret_addr", 32'(bus.ret_addr), 32'h08);
    check("fullswap.top", 32'(bus.top_addr), 32'hAA);
    check("fullswap.overflow", 32'(bus.overflow), 1);
    drive(0, 1, 1, '0);
    check("ovfpop.ret_addr", 32'(bus.ret_addr), 32'hAA);
    check("ovfpop.ret_valid", 32'(bus.ret_valid), 1);
    check("ovfpop.overflow", 32'(bus.overflow), 0);
    check_model("postfill");

    // Push+pop on an empty stack: underflow, but the push still lands.
    while (stk.size() != 0) drive(0, 1, 0, '0);
    drive(0, 0, 1, '0);
    drive(1, 1, 0, 16'h0BEE);
    check("emptyswap.level", 32'(bus.level), 1);
    check("emptyswap.top", 32'(bus.top_addr), 32'h0BEE);
    check("emptyswap.ret_valid", 32'(bus.ret_valid), 0);
    check("emptyswap.underflow", 32'(bus.underflow), 1);
    check_model("emptyswap");

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 600; k++) begin
      logic  p, q, c;
      addr_t a;
      if (k < 300) begin
        p = ($urandom_range(99) < 65);
        q = ($urandom_range(99) < 35);
      end else begin
        p = ($urandom_range(99) < 35);
        q = ($urandom_range(99) < 65);
      end
      c = ($urandom_range(99) < 10);
      a = addr_t'($urandom);
      drive(p, q, c, a);
      check_model($sformatf("rnd%0d", k));
    end

    // ---------------- asynchronous reset mid-sequence ----------------
    drive(0, 0, 1, '0);
    while (stk.size() != 0) drive(0, 1, 0, '0);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, addr_t'(16'h0500 + i));
    drive(0, 1, 0, '0);
    check("prereset.level", 32'(bus.level), 5);
    check("prereset.ret_valid", 32'(bus.ret_valid), 1);
    bus.pop = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_reset_vals("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 16'h0077);
    check("postreset.level", 32'(bus.level), 1);
    check("postreset.top", 32'(bus.top_addr), 32'h0077);
    drive(0, 1, 0, '0);
    drive(0, 0, 0, '0);

    // ---------------- CALL/RET with a modelled PC ----------------
    // PC loads ret_addr in the cycle where ret_valid is high.
    pc    = 16'h0100;
    loads = 0;
    for (int k = 0; k < 20; k++) begin
      call = (pc == 16'h0105);
      ret  = (pc == 16'h0203);
      ld   = bus.ret_valid;
      la   = bus.ret_addr;
      drive(call, ret, 1'b0, addr_t'(pc + 16'd1));
      if (ld) begin
        pc = la;
        loads++;
        check("pc.resume", 32'(pc), 32'h0106);
      end else if (call) begin
        pc = 16'h0200;
      end else begin
        pc = pc + 16'd1;
      end
    end
    check("pc.loads", 32'(loads), 1);
    check("pc.final", 32'(pc), 32'h010F);
    check("pc.stack_empty", 32'(bus.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/return_address_stack.md
# return_address_stack

Hardware return-address stack for the SAP-2 CPU's CALL/RET path. On CALL the control unit pushes the address of the next instruction, taken from the program counter output. On RET it pops the saved address, which returns one cycle later as a registered value to drive the program counter's parallel-load input. The block sits between the program counter and the control unit and provides full/empty status plus sticky overflow/underflow error flags for the controller.

## Interface
- `DEPTH`, default `RAS_DEPTH` (8, from `arch_defs_pkg`): number of stacked return addresses; must be ≥ 2.
- `ADDR_WIDTH`, from `arch_defs_pkg`: width of a stored address. This is a package constant, not a module parameter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `push`  in  1  store `push_addr` on top of stack (CALL).
- `pop`  in  1  remove the top entry and return it (RET).
- `push_addr`  in  ADDR_WIDTH  return address to save; normally PC output.
- `clear_err`  in  1  clear `overflow`/`underflow`.
- `ret_addr`  out  ADDR_WIDTH  registered popped address; feeds PC `counter_in`.
- `ret_valid`  out  1  one-cycle pulse: `ret_addr` updated by a successful pop.
- `top_addr`  out  ADDR_WIDTH  combinational view of the current top entry; 0 when empty.
- `level`  out  $clog2(DEPTH+1)  current entry count (0..DEPTH).
- `empty`  out  1  `level == 0`.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky: push was attempted while full.
- `underflow`  out  1  sticky: pop was attempted while empty.

## Operation
- Storage: DEPTH × ADDR_WIDTH registers. `sp` holds the entry count; the top entry is `mem[sp-1]`.
- Push only, not full: `mem[sp] <= push_addr`; `sp <= sp+1`.
- Push only, full: no write; `sp` unchanged; `overflow <= 1`.
- Pop only, not empty: `ret_addr <= mem[sp-1]`; `sp <= sp-1`; `ret_valid <= 1`.
- Pop only, empty: `ret_addr` holds; `ret_valid <= 0`; `underflow <= 1`.
- Push and pop together, not empty (including full): swap the top entry.
  - `ret_addr <= mem[sp-1]`, `mem[sp-1] <= push_addr`, `ret_valid <= 1`.
  - `sp` unchanged; no overflow.
- Push and pop together, empty: `underflow <= 1`; the push still completes (`mem[0] <= push_addr`, `sp <= 1`); `ret_valid <= 0`.
- Neither asserted: state holds; `ret_valid <= 0`.
- `clear_err` clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- `sp` never wraps. Arithmetic is unsigned at the `level` width, and the guards above prevent any wrap.

## Timing
- Reset assertion, including mid-operation, immediately forces:
  - `sp=0`, `ret_addr=0`, `ret_valid=0`, `overflow=0`, `underflow=0`.
  - Resulting outputs: `empty=1`, `full=0`, `level=0`, `top_addr=0`.
  - Memory contents are not reset and are don't-care.
- Reset deassertion is synchronized externally; the first update occurs on the first rising edge after release.
- Push latency: `top_addr`, `level`, `full` and `empty` reflect the push from the following cycle.
- Pop latency: exactly 1 cycle. `ret_addr`/`ret_valid` are valid the cycle after `pop`, so the controller asserts PC `load` in that cycle.
- `ret_valid` stays high for exactly one cycle per successful pop. Back-to-back pops give consecutive pulses with successive addresses.
- `push`/`pop` are level-sampled every edge; the controller asserts each for one cycle per instruction.

## Structure
- `arch_defs_pkg` gains `RAS_DEPTH = 8`. It reuses the existing `ADDR_WIDTH`.
- Single module; the storage array is inline. A sub-module is not warranted: the read/write logic is shared with the pointer logic.
- Expected size: roughly 120–180 lines of RTL including flags.

## Test plan
- Reset, then push 0x12, 0x34, 0x56 -> `level=3`, `top_addr=0x56`; then three pops -> `ret_addr` 0x56, 0x34, 0x12 on consecutive cycles with `ret_valid=1` each; then `empty=1`.
- Fill to DEPTH (pushes 0x01..0x08), then push 0xFF -> `full=1`, `overflow=1`, `top_addr=0x08`; pop -> `ret_addr=0x08`.
- Pop while empty -> `underflow=1`, `ret_valid=0`, `ret_addr` unchanged; `clear_err` -> both flags 0; `clear_err` with a simultaneous empty pop -> `underflow` stays 1.
- With stack [0x10, 0x20], push 0x99 with pop -> `ret_addr=0x20`, `ret_valid=1`, `level=2`, `top_addr=0x99`.
- Assert reset mid-sequence with `level=5` -> all outputs reach reset values before the next clock edge; first push after release lands at `level=1`.
- PC integration: CALL/RET loop with PC `load` driven by `ret_valid` -> PC resumes at the saved address +0 and increments normally afterward.
